// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Purpose:
//   Word-organised data memory behind a valid/ready request channel and a
//   valid/ready response channel. An accepted request is held for
//   WAIT_CYCLES wait states. The memory is then accessed exactly once, and
//   the response is held until the initiator takes it. Misaligned or
//   out-of-range requests produce an error response and never touch memory.
//
// Parameters:
//   DEPTH        number of 32-bit words stored
//   WAIT_CYCLES  wait states between request acceptance and response (0 ok)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous reset, active low
//   req_valid  in   request present
//   req_ready  out  responder idle and able to accept a request
//   req_we     in   1 = write, 0 = read
//   req_addr   in   byte address, word index = req_addr[31:2]
//   req_wdata  in   write data
//   req_be     in   byte-lane enables for writes
//   rsp_valid  out  response present
//   rsp_ready  in   initiator accepts the response
//   rsp_rdata  out  read data (0 for writes and errors)
//   rsp_err    out  request was misaligned or out of range
//   busy       out  high whenever a transaction is in flight
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [29:0] DEPTH_WORDS = 30'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;

    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;

    logic [31:0]      mem [DEPTH];

    logic             req_hs;
    logic             enter_resp;
    logic             acc_we;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [3:0]       acc_be;
    logic             acc_err;
    logic [IDX_W-1:0] acc_idx;

    // Ready is also held low while reset is asserted, so nothing can be
    // accepted before the block is out of reset.
    assign req_ready = (state_q == S_IDLE) && reset;
    assign req_hs    = req_valid && req_ready;

    // With no wait states the access happens on the acceptance edge itself,
    // before the request registers hold anything. The live inputs are
    // therefore used while idle, and the captured copy is used otherwise.
    assign acc_we    = (state_q == S_IDLE) ? req_we    : we_q;
    assign acc_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign acc_be    = (state_q == S_IDLE) ? req_be    : be_q;

    // The full 30-bit word index is range-checked before it is truncated.
    // Out-of-range addresses can then never alias onto a low word.
    assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= DEPTH_WORDS);
    assign acc_idx = acc_addr[IDX_W+1:2];

    // This is the single edge on which memory is read or written.
    assign enter_resp = ((state_q == S_IDLE) && req_hs && (WAIT_CYCLES == 0)) ||
                        ((state_q == S_WAIT) && (cnt_q == '0));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_hs) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Response payload is captured on the access edge and then left alone.
    // It stays stable for as long as the initiator stalls.
    always_comb begin
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (enter_resp) begin
            rsp_err_d   = acc_err;
            rsp_rdata_d = (!acc_err && !acc_we) ? mem[acc_idx] : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (req_hs) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

    // Storage is intentionally not reset. The state register is forced to
    // IDLE asynchronously, and ready is gated by reset. As a result,
    // enter_resp cannot fire while reset is held, so a transaction abandoned
    // in WAIT never writes.
    always_ff @(posedge clk) begin
        if (enter_resp && acc_we && !acc_err) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (acc_be[lane]) begin
                    mem[acc_idx][8*lane +: 8] <= acc_wdata[8*lane +: 8];
                end
            end
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule
